// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: SPI-style LCD bus receiver with input synchronizers and byte handshake.
// Define LCD_RX_FIFO_EN for a 4-entry output FIFO; default is a single holding register.
module lcd_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        lcd_reset,
    input  logic        sck,
    input  logic        sda,
    input  logic        rs,
    input  logic        cs,
    output logic [7:0]  rx_data,
    output logic        rx_rs,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] rx_count
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] r_sck_s;
    logic [SYNC_STAGES-1:0] r_sda_s;
    logic [SYNC_STAGES-1:0] r_rs_s;
    logic [SYNC_STAGES-1:0] r_cs_s;
    logic [SYNC_STAGES-1:0] r_lrst_s;

    logic        r_sck_prev;
    state_t      r_state;
    logic [2:0]  r_bitcnt;
    // Only seven bits of history are kept; the eighth is the live sda bit.
    logic [6:0]  r_shreg;
    logic        r_frame_err;
    logic [15:0] r_rx_count;

    logic        w_sck;
    logic        w_sda;
    logic        w_rs;
    logic        w_cs;
    logic        w_lrst_n;
    logic        w_rise;
    logic        w_shift_en;
    logic        w_done;
    logic        w_abort;
    logic [2:0]  w_cnt_nxt;
    logic [7:0]  w_byte;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sck_s  <= '0;
            r_sda_s  <= '0;
            r_rs_s   <= '0;
            r_cs_s   <= '1;
            r_lrst_s <= '1;
        end else begin
            r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], sck};
            r_sda_s  <= {r_sda_s[SYNC_STAGES-2:0], sda};
            r_rs_s   <= {r_rs_s[SYNC_STAGES-2:0], rs};
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], cs};
            r_lrst_s <= {r_lrst_s[SYNC_STAGES-2:0], lcd_reset};
        end
    end

    assign w_sck    = r_sck_s[SYNC_STAGES-1];
    assign w_sda    = r_sda_s[SYNC_STAGES-1];
    assign w_rs     = r_rs_s[SYNC_STAGES-1];
    assign w_cs     = r_cs_s[SYNC_STAGES-1];
    assign w_lrst_n = r_lrst_s[SYNC_STAGES-1];

    assign w_rise     = w_sck & ~r_sck_prev;
    assign w_shift_en = (r_state == SHIFT) & w_lrst_n & w_rise;
    assign w_byte     = {r_shreg, w_sda};
    assign w_done     = w_shift_en & (r_bitcnt == 3'd7);
    assign w_cnt_nxt  = w_shift_en ? r_bitcnt + 3'd1 : r_bitcnt;
    // The edge is applied before judging a cs release, so a byte closing on it is not an abort.
    assign w_abort    = (r_state == SHIFT) & w_lrst_n & w_cs
                      & (w_cnt_nxt != 3'd0);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sck_prev  <= 1'b0;
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sck_prev  <= w_sck;
            r_frame_err <= w_abort;
            if (!w_lrst_n) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_shreg  <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_cs)
                            r_state <= SHIFT;
                    end
                    SHIFT: begin
                        if (w_shift_en) begin
                            r_shreg  <= w_byte[6:0];
                            r_bitcnt <= w_cnt_nxt;
                        end
                        if (w_cs) begin
                            r_state  <= IDLE;
                            r_bitcnt <= '0;
                            r_shreg  <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset)
            r_rx_count <= '0;
        else if (w_done)
            r_rx_count <= r_rx_count + 16'd1;
    end

    assign frame_err = r_frame_err;
    assign rx_count  = r_rx_count;

`ifdef LCD_RX_FIFO_EN
    logic [8:0] r_mem [4];
    logic [1:0] r_rd;
    logic [1:0] r_wr;
    logic [2:0] r_cnt;
    logic       r_overrun;
    logic       w_pop;
    logic       w_full;
    logic       w_push;

    assign w_pop  = (r_cnt != 3'd0) & rx_ready;
    assign w_full = (r_cnt == 3'd4);
    assign w_push = w_done & (~w_full | w_pop);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                r_mem[i] <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_done & w_full & ~w_pop;
            if (w_push) begin
                r_mem[r_wr] <= {w_rs, w_byte};
                r_wr        <= r_wr + 2'd1;
            end
            if (w_pop)
                r_rd <= r_rd + 2'd1;
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    assign rx_valid         = (r_cnt != 3'd0);
    assign {rx_rs, rx_data} = r_mem[r_rd];
    assign overrun          = r_overrun;
`else
    logic [7:0] r_data;
    logic       r_rs;
    logic       r_valid;
    logic       r_overrun;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_data    <= '0;
            r_rs      <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_done & r_valid & ~rx_ready;
            if (w_done) begin
                r_data  <= w_byte;
                r_rs    <= w_rs;
                r_valid <= 1'b1;
            end else if (rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_valid = r_valid;
    assign rx_data  = r_data;
    assign rx_rs    = r_rs;
    assign overrun  = r_overrun;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed table-driven bench for lcd_spi_rx.
// Honours LCD_RX_FIFO_EN for the overrun expectations.
module tb_lcd_spi_rx;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        lcd_reset;
    logic        sck;
    logic        sda;
    logic        rs;
    logic        cs;
    logic [7:0]  rx_data;
    logic        rx_rs;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic [15:0] rx_count;

    int n_chk  = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vl_cnt = 0;
    logic [8:0] q[$];

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[5];

    lcd_spi_rx #(.SYNC_STAGES(2)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .lcd_reset(lcd_reset),
        .sck      (sck),
        .sda      (sda),
        .rs       (rs),
        .cs       (cs),
        .rx_data  (rx_data),
        .rx_rs    (rx_rs),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_count (rx_count)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rx_valid && rx_ready)
            q.push_back({rx_rs, rx_data});
        if (rx_valid)
            vl_cnt++;
        if (frame_err)
            fe_cnt++;
        if (overrun)
            ov_cnt++;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(string nm, logic [7:0] ed, logic er);
        logic [8:0] v;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no byte expected %0h", nm, ed);
        end else begin
            v = q.pop_front();
            chk({nm, " data"}, {24'd0, v[7:0]}, {24'd0, ed});
            chk({nm, " rs"}, {31'd0, v[8]}, {31'd0, er});
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_bit(logic b);
        sck = 1'b0;
        sda = b;
        tick(4);
        sck = 1'b1;
        tick(4);
    endtask

    task automatic send_bits(logic rsv, logic [7:0] d, int n);
        rs = rsv;
        for (int i = 7; i > 7 - n; i--)
            send_bit(d[i]);
        sck = 1'b0;
        tick(4);
    endtask

    int         fe0;
    int         ov0;
    int         vl0;
    logic [7:0] bv;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 16'd1};
        vecs[1] = '{1'b0, 8'h01, 16'd2};
        vecs[2] = '{1'b1, 8'h3C, 16'd3};
        vecs[3] = '{1'b1, 8'hFF, 16'd4};
        vecs[4] = '{1'b0, 8'h00, 16'd5};

        reset     = 1'b1;
        lcd_reset = 1'b1;
        sck       = 1'b0;
        sda       = 1'b0;
        rs        = 1'b0;
        cs        = 1'b1;
        rx_ready  = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst rx_rs", {31'd0, rx_rs}, 32'd0);
        chk("rst rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        chk("rst rx_count", {16'd0, rx_count}, 32'd0);

        // Back-to-back bytes with cs held low
        fe0 = fe_cnt;
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            send_bits(vecs[i].rs, vecs[i].data, 8);
            tick(8);
            chk($sformatf("vec%0d nbytes", i), q.size(), 32'd1);
            pop_chk($sformatf("vec%0d", i), vecs[i].data, vecs[i].rs);
            chk($sformatf("vec%0d count", i), {16'd0, rx_count},
                {16'd0, vecs[i].cnt});
        end
        cs = 1'b1;
        tick(8);
        chk("vec frame_err", fe_cnt - fe0, 32'd0);

        // Aborted byte after 5 bits
        fe0 = fe_cnt;
        vl0 = vl_cnt;
        cs = 1'b0;
        tick(4);
        send_bits(1'b0, 8'hB7, 5);
        cs = 1'b1;
        tick(8);
        chk("abort frame_err", fe_cnt - fe0, 32'd1);
        chk("abort no valid", vl_cnt - vl0, 32'd0);
        chk("abort count", {16'd0, rx_count}, 32'd5);
        cs = 1'b0;
        tick(4);
        send_bits(1'b1, 8'h7E, 8);
        cs = 1'b1;
        tick(8);
        chk("7E nbytes", q.size(), 32'd1);
        pop_chk("7E", 8'h7E, 1'b1);
        chk("7E frame_err", fe_cnt - fe0, 32'd1);
        chk("7E count", {16'd0, rx_count}, 32'd6);

        // Last edge and cs release in the same cycle
        fe0 = fe_cnt;
        bv = 8'hC3;
        cs = 1'b0;
        rs = 1'b0;
        tick(4);
        for (int i = 7; i > 0; i--)
            send_bit(bv[i]);
        sck = 1'b0;
        sda = bv[0];
        tick(4);
        sck = 1'b1;
        cs  = 1'b1;
        tick(4);
        sck = 1'b0;
        tick(8);
        chk("same nbytes", q.size(), 32'd1);
        pop_chk("same", 8'hC3, 1'b0);
        chk("same frame_err", fe_cnt - fe0, 32'd0);
        chk("same count", {16'd0, rx_count}, 32'd7);

        // LCD reset mid-byte
        fe0 = fe_cnt;
        cs = 1'b0;
        tick(4);
        send_bits(1'b0, 8'hE0, 3);
        lcd_reset = 1'b0;
        tick(6);
        lcd_reset = 1'b1;
        tick(6);
        send_bits(1'b1, 8'h55, 8);
        cs = 1'b1;
        tick(8);
        chk("lrst nbytes", q.size(), 32'd1);
        pop_chk("lrst", 8'h55, 1'b1);
        chk("lrst frame_err", fe_cnt - fe0, 32'd0);
        chk("lrst count", {16'd0, rx_count}, 32'd8);

        // Overrun with consumer stalled
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++)
            send_bits(1'b0, 8'h10 + 8'(i), 8);
        cs = 1'b1;
        tick(8);
        chk("ovr count", {16'd0, rx_count}, 32'd14);
        chk("ovr valid", {31'd0, rx_valid}, 32'd1);
`ifdef LCD_RX_FIFO_EN
        chk("ovr pulses", ov_cnt - ov0, 32'd2);
        chk("ovr head", {24'd0, rx_data}, 32'h10);
        rx_ready = 1'b1;
        tick(8);
        chk("ovr nbytes", q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            pop_chk($sformatf("drain%0d", i), 8'h10 + 8'(i), 1'b0);
`else
        chk("ovr pulses", ov_cnt - ov0, 32'd5);
        chk("ovr head", {24'd0, rx_data}, 32'h15);
        rx_ready = 1'b1;
        tick(8);
        chk("ovr nbytes", q.size(), 32'd1);
        pop_chk("drain", 8'h15, 1'b0);
`endif
        chk("drain valid", {31'd0, rx_valid}, 32'd0);

        // Byte counter wrap
        force dut.r_rx_count = 16'hFFFF;
        tick(2);
        release dut.r_rx_count;
        tick(2);
        chk("wrap preset", {16'd0, rx_count}, 32'hFFFF);
        cs = 1'b0;
        tick(4);
        send_bits(1'b0, 8'h81, 8);
        tick(4);
        chk("wrap first", {16'd0, rx_count}, 32'h0000);
        send_bits(1'b1, 8'h42, 8);
        cs = 1'b1;
        tick(8);
        chk("wrap second", {16'd0, rx_count}, 32'h0001);
        pop_chk("wrap b0", 8'h81, 1'b0);
        pop_chk("wrap b1", 8'h42, 1'b1);

        // System reset mid-byte
        fe0 = fe_cnt;
        cs = 1'b0;
        tick(4);
        send_bits(1'b0, 8'hF0, 4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        chk("mrst frame_err", fe_cnt - fe0, 32'd0);
        chk("mrst count", {16'd0, rx_count}, 32'd0);
        chk("mrst nbytes", q.size(), 32'd0);
        send_bits(1'b1, 8'h9A, 8);
        cs = 1'b1;
        tick(8);
        pop_chk("mrst", 8'h9A, 1'b1);
        chk("mrst count2", {16'd0, rx_count}, 32'd1);
        chk("mrst frame_err2", fe_cnt - fe0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each serial input (legal range 2..4).
REQ-002 SHALL have port sysclk, input, 1 bit: the single system clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port lcd_reset, input, 1 bit: LCD reset line from the display driver's reset_o, active-low.
REQ-005 SHALL have port sck, input, 1 bit: serial clock; data is sampled on its rising edge.
REQ-006 SHALL have port sda, input, 1 bit: serial data, MSB first.
REQ-007 SHALL have port rs, input, 1 bit: register select (0 = command, 1 = data).
REQ-008 SHALL have port cs, input, 1 bit: chip select, active-low.
REQ-009 SHALL have port rx_data, output, 8 bits: received byte.
REQ-010 SHALL have port rx_rs, output, 1 bit: rs value captured with rx_data.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data and rx_rs hold a byte.
REQ-012 SHALL have port rx_ready, input, 1 bit: consumer accepts the byte.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted byte.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-015 SHALL have port rx_count, output, 16 bits: count of completed bytes.

Function
REQ-016 SHALL pass sck, sda, rs, cs and lcd_reset through SYNC_STAGES flops each; all logic below SHALL use only the synchronized copies.
REQ-017 SHALL detect an sck rising edge as sync sck = 1 with previous sync sck = 0; sck high and low times of at least SYNC_STAGES+1 sysclk cycles each are guaranteed by the sender.
REQ-018 SHALL implement the states IDLE (cs high) and SHIFT (cs low): IDLE -> SHIFT on sync cs = 0; SHIFT -> IDLE on sync cs = 1.
REQ-019 SHALL, in SHIFT on each sck rising edge, shift sda into an 8-bit register MSB first and increment a 3-bit bit counter.
REQ-020 SHALL, on the 8th edge, capture the byte and sync rs together, clear the bit counter, and deliver the byte to the output stage, with rx_valid asserted the cycle after that edge cycle.
REQ-021 SHALL accept consecutive bytes while cs stays low, with no cs toggle needed between bytes.
REQ-022 SHALL ignore sck edges in IDLE.
REQ-023 SHALL, when cs deasserts with the bit counter nonzero, discard the partial byte, clear the counter and pulse frame_err for one cycle.
REQ-024 SHALL, when an sck edge and cs deassertion fall in the same cycle, process the edge first; if that edge completes a byte, the byte SHALL be delivered and no frame_err raised.
REQ-025 SHALL, while sync lcd_reset = 0, hold the bit counter and shift register at 0, stay in IDLE, and produce no bytes or errors; output-stage contents and rx_count SHALL be kept.
REQ-026 SHALL complete a handshake when rx_valid and rx_ready are both high on a rising sysclk edge.
REQ-027 SHALL increment rx_count on every completed byte, including dropped ones, and wrap from 0xFFFF to 0x0000.

Reset
REQ-028 SHALL, on reset high at a sysclk edge, clear the synchronizers to idle levels (sck 0, cs 1, lcd_reset 1, sda 0, rs 0), select IDLE, and set every output to 0, including rx_data, rx_rs, rx_valid, frame_err, overrun and rx_count.
REQ-029 SHALL, on reset asserted mid-byte, discard the partial byte without a frame_err.

Configuration
REQ-030 SHALL, with macro LCD_RX_FIFO_EN defined, buffer bytes in a 4-entry FIFO of {rs, byte}; rx_valid = FIFO not empty and the head is presented; a handshake pops; a byte arriving when full is dropped with overrun pulsed; simultaneous pop and push when full SHALL accept both.
REQ-031 SHALL, without LCD_RX_FIFO_EN, use a single holding register; rx_valid stays high until the handshake; a new byte while rx_valid is high and rx_ready is low overwrites the register and pulses overrun; a handshake and a new byte in the same cycle SHALL load the new byte with no overrun.

Verification
REQ-032 SHALL cover: cs low, rs = 0, byte 0xA5 sent MSB first, rx_ready = 1 -> one byte with rx_data = 0xA5, rx_rs = 0, rx_count = 1.
REQ-033 SHALL cover: cs held low, bytes 0x01 (rs = 0) then 0x3C (rs = 1) -> two bytes in order with rx_rs 0 then 1, and no frame_err.
REQ-034 SHALL cover: cs raised after 5 bits -> frame_err pulses once, no rx_valid, and the next full byte 0x7E is received correctly.
REQ-035 SHALL cover: rx_ready = 0 while 6 bytes 0x10..0x15 are sent -> with FIFO, 2 overrun pulses, then draining yields 0x10..0x13; without FIFO, 5 overrun pulses and rx_data = 0x15.
REQ-036 SHALL cover: lcd_reset low during a byte, then high, then byte 0x55 -> only 0x55 is received; rx_count preset near 0xFFFF and incremented twice -> wraps to 0x0001.
